// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants for the RISC-V front end.
// Contents:
//   PC_W_DEF, INSTR_W_DEF : default program counter and instruction widths
//   NOP_INSTR             : canonical NOP (addi x0, x0, 0), shown when no
//                           instruction is available
//   SIDE_ISDIV            : bit index of the isdiv flag in the sideband field
package riscv_pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int SIDE_ISDIV = 0;

endpackage

// File: rtl/if_id_queue.sv
// Instruction queue between the fetch and decode stages.
//
// This is a first-word fall-through FIFO. The head entry is read straight
// from storage. A flush clears the queue (branch redirect). A stall holds
// the head entry while new entries can still be written.
//
// Ports:
//   sys_clk, sys_rst_n     : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : fetch-side handshake
//   pc_i, instr_i, side_i  : offered entry
//   flush_i                : discard all entries, drop the offered entry
//   stall_i                : hold the head entry
//   out_valid_o            : a head entry is present
//   pc_o, instr_o, side_o  : head entry (NOP, 0, 0 when empty)
//   count_o                : occupied entries
module if_id_queue #(
    parameter int                 DEPTH     = 4,
    parameter int                 PC_W      = riscv_pipe_pkg::PC_W_DEF,
    parameter int                 INSTR_W   = riscv_pipe_pkg::INSTR_W_DEF,
    parameter int                 SIDE_W    = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(riscv_pipe_pkg::NOP_INSTR)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PC_W-1:0]            pc_i,
    input  logic [INSTR_W-1:0]         instr_i,
    input  logic [SIDE_W-1:0]          side_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    output logic                       out_valid_o,
    output logic [PC_W-1:0]            pc_o,
    output logic [INSTR_W-1:0]         instr_o,
    output logic [SIDE_W-1:0]          side_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [SIDE_W-1:0]  side_mem_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic enq;
    logic deq;

    // in_ready_o depends only on the registered count and flush_i. It has
    // no path from stall_i, so fetch timing does not depend on decode.
    // A full queue raises ready only one cycle after a dequeue.
    always_comb begin
        in_ready_o  = (count_q != FULL_CNT) && !flush_i;
        out_valid_o = (count_q != '0);
        enq         = in_valid_i && in_ready_o;
        deq         = out_valid_o && !stall_i && !flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset and is not cleared by flush. The empty-queue
    // output muxing hides any stale contents.
    always_ff @(posedge sys_clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]    <= pc_i;
            instr_mem_q[wr_ptr_q] <= instr_i;
            side_mem_q[wr_ptr_q]  <= side_i;
        end
    end

    always_comb begin
        if (out_valid_o) begin
            pc_o    = pc_mem_q[rd_ptr_q];
            instr_o = instr_mem_q[rd_ptr_q];
            side_o  = side_mem_q[rd_ptr_q];
        end else begin
            pc_o    = '0;
            instr_o = NOP_INSTR;
            side_o  = '0;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int SIDE_W  = 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [PC_W-1:0]    pc_i;
    logic [INSTR_W-1:0] instr_i;
    logic [SIDE_W-1:0]  side_i;
    logic               flush_i;
    logic               stall_i;
    logic               out_valid_o;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_o;
    logic [SIDE_W-1:0]  side_o;
    logic [2:0]         count_o;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .side_i      (side_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .out_valid_o (out_valid_o),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .side_o      (side_o),
        .count_o     (count_o)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [SIDE_W-1:0]  side;
    } entry_t;

    entry_t model_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the fetch/decode handshake rules.
    always @(posedge sys_clk) begin
        if (sys_rst_n) begin
            bit acc, pop;
            entry_t e;
            acc = in_valid_i && (model_q.size() < DEPTH) && !flush_i;
            pop = (model_q.size() > 0) && !stall_i && !flush_i;
            if (flush_i) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (acc) begin
                    e.pc = pc_i; e.instr = instr_i; e.side = side_i;
                    model_q.push_back(e);
                end
            end
        end
    end

    always @(negedge sys_rst_n) model_q.delete();

    // Monitor: compare the presented head against the scoreboard front.
    always @(negedge sys_clk) begin
        if (mon_en && sys_rst_n) begin
            chk("mon_count", 64'(count_o), 64'(model_q.size()));
            chk("mon_valid", 64'(out_valid_o), 64'(model_q.size() != 0));
            chk("mon_ready", 64'(in_ready_o), 64'((model_q.size() != DEPTH) && !flush_i));
            if (model_q.size() != 0) begin
                chk("mon_pc",    64'(pc_o),    64'(model_q[0].pc));
                chk("mon_instr", 64'(instr_o), 64'(model_q[0].instr));
                chk("mon_side",  64'(side_o),  64'(model_q[0].side));
            end else begin
                chk("mon_pc_empty",    64'(pc_o),    64'(0));
                chk("mon_instr_empty", 64'(instr_o), 64'(NOP));
                chk("mon_side_empty",  64'(side_o),  64'(0));
            end
        end
    end

    // Inputs are applied 1 ns after a rising edge and take effect on the next edge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
        in_valid_i = v;
        pc_i       = pc;
        instr_i    = $urandom;
        side_i     = SIDE_W'($urandom_range(0, 1));
        stall_i    = st;
        flush_i    = fl;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("async_rst_count", 64'(count_o), 64'(0));
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // Reset state
        chk("rst_valid", 64'(out_valid_o), 64'(0));
        chk("rst_ready", 64'(in_ready_o), 64'(1));
        chk("rst_instr", 64'(instr_o), 64'(NOP));
        chk("rst_count", 64'(count_o), 64'(0));

        // Fill to full while decode stalls
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("full_count", 64'(count_o), 64'(4));
        chk("full_ready", 64'(in_ready_o), 64'(0));
        step();
        chk("full_head_pc", 64'(pc_o), 64'(0));
        chk("full_count_hold", 64'(count_o), 64'(4));

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            chk("drain_pc", 64'(pc_o), 64'(i * 4));
            step();
        end
        chk("drain_valid", 64'(out_valid_o), 64'(0));
        chk("drain_instr", 64'(instr_o), 64'(NOP));

        // Flush against a simultaneous offer
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(i * 4), 1'b1, 1'b0);
            step();
        end
        chk("pre_flush_count", 64'(count_o), 64'(3));
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_valid", 64'(out_valid_o), 64'(0));
        step();
        chk("flush_no_0x40", 64'(pc_o == 32'h40), 64'(0));

        // Simultaneous enqueue and dequeue at count 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
            if (i < 3) chk("sim_order_pc", 64'(pc_o), 64'(32'h100 + 32'(i * 4)));
            else       chk("sim_order_pc", 64'(pc_o), 64'(32'h200 + 32'((i - 3) * 4)));
            step();
            chk("sim_count", 64'(count_o), 64'(3));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) step();
        chk("sim_drained", 64'(count_o), 64'(0));

        // Asynchronous reset between edges
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_arst_count", 64'(count_o), 64'(2));
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'(0));
        chk("arst_valid", 64'(out_valid_o), 64'(0));
        chk("arst_ready", 64'(in_ready_o), 64'(1));
        chk("arst_instr", 64'(instr_o), 64'(NOP));
        step();
        sys_rst_n = 1'b1;
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_arst_count", 64'(count_o), 64'(1));
        chk("post_arst_pc", 64'(pc_o), 64'(32'h400));
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60),
                  {$urandom_range(0, 1023), 2'b00},
                  1'($urandom_range(0, 99) < 40),
                  1'($urandom_range(0, 99) < 5));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (6) step();
        chk("final_empty", 64'(count_o), 64'(0));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the entry count; it SHALL be a power of two in the range 2..16.
REQ-002 The parameter PC_W SHALL default to 32 and set the program counter width.
REQ-003 The parameter INSTR_W SHALL default to 32 and set the instruction width.
REQ-004 The parameter SIDE_W SHALL default to 1 and set the sideband width (isdiv flag and any future per-instruction flags).
REQ-005 The parameter NOP_INSTR SHALL default to 32'h0000_0013 and set the instruction presented when the queue holds no valid entry.
REQ-006 The design SHALL have one clock and an asynchronous active-low reset, with these ports:
- sys_clk, input, 1 bit: the only clock; all state changes on its rising edge.
- sys_rst_n, input, 1 bit: asynchronous active-low reset.
- in_valid_i, input, 1 bit: the fetch stage offers an entry.
- in_ready_o, output, 1 bit: the queue can accept an entry.
- pc_i, input, PC_W bits: PC of the offered instruction.
- instr_i, input, INSTR_W bits: the offered instruction.
- side_i, input, SIDE_W bits: sideband bits of the offered instruction.
- flush_i, input, 1 bit: discard all entries (branch or jump redirect).
- stall_i, input, 1 bit: decode hazard; the head entry is held.
- out_valid_o, output, 1 bit: a head entry is present.
- pc_o, output, PC_W bits: head PC.
- instr_o, output, INSTR_W bits: head instruction.
- side_o, output, SIDE_W bits: head sideband bits.
- count_o, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-007 Enqueue SHALL occur on a rising edge when in_valid_i=1, in_ready_o=1 and flush_i=0; the entry {pc_i, instr_i, side_i} is written at the tail.
REQ-008 in_ready_o SHALL equal (count_o != DEPTH) AND NOT flush_i; it SHALL be a function of registered state and flush_i only, with no path from stall_i.
REQ-009 out_valid_o SHALL equal (count_o != 0).
REQ-010 Dequeue SHALL occur on a rising edge when out_valid_o=1, stall_i=0 and flush_i=0.
REQ-011 The head fields SHALL be driven from storage at the read pointer (first-word fall-through); an enqueue into an empty queue SHALL appear at the outputs one cycle later, with no combinational input-to-output bypass.
REQ-012 When out_valid_o=0: instr_o SHALL equal NOP_INSTR, pc_o SHALL be 0 and side_o SHALL be 0.
REQ-013 A simultaneous enqueue and dequeue SHALL leave count_o unchanged and advance both pointers, including when count_o equals DEPTH-1 or 1.
REQ-014 When full, dequeue SHALL proceed normally; in_ready_o SHALL rise in the cycle after the dequeue.
REQ-015 A dequeue attempt on an empty queue SHALL have no effect.
REQ-016 flush_i=1 SHALL dominate stall_i and in_valid_i: on that edge, count_o and both pointers become 0 and the offered entry is dropped; out_valid_o=0 from the next cycle.
REQ-017 stall_i=1 with flush_i=0 SHALL hold the head entry and its outputs stable while enqueue continues until full.
REQ-018 The read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; count_o SHALL never exceed DEPTH or underflow.
REQ-019 Storage contents SHALL not be cleared by flush or reset; only pointers and count are cleared.

Reset
REQ-020 sys_rst_n=0 SHALL immediately clear count_o and both pointers, independent of sys_clk, giving out_valid_o=0, in_ready_o=1, instr_o=NOP_INSTR, pc_o=0 and side_o=0.
REQ-021 Reset asserted mid-operation SHALL discard all entries; after release, the first rising edge with in_valid_i=1 SHALL enqueue normally.

Structure
REQ-022 NOP_INSTR, the default PC_W and INSTR_W, and a sideband bit index constant (SIDE_ISDIV=0) SHALL reside in the shared package riscv_pipe_pkg.
REQ-023 The block SHALL be a single module with pointers, count and storage array inline; no sub-module is required.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset check: after reset, expect out_valid_o=0, in_ready_o=1, instr_o=32'h00000013, count_o=0.
- Fill to full: enqueue PCs 0x0, 0x4, 0x8, 0xC with stall_i=1. Expect count_o=4 and in_ready_o=0; a fifth offer (PC 0x10) is not accepted and pc_o stays 0x0.
- Drain in order: with stall_i=0 and in_valid_i=0, expect pc_o sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, then out_valid_o=0 and instr_o=NOP_INSTR.
- Flush versus enqueue: with count_o=3, assert flush_i=1 together with in_valid_i=1 (PC 0x40). Next cycle expect count_o=0 and out_valid_o=0; PC 0x40 is never output.
- Simultaneous enqueue and dequeue: with count_o=3 and stall_i=0, offer one entry per cycle for 8 cycles. Expect count_o to stay 3, the pointers to wrap twice, and output order to match input order.
- Asynchronous reset mid-stream: assert sys_rst_n=0 between clock edges while count_o=2. Expect count_o=0 and out_valid_o=0 immediately, before the next edge.
